// File: rtl/adsp_dag_gen_pkg.sv
// Shared ADSP data-address-generator package: register classes and the
// width-generic helpers for circular wrap, base masking and bit reversal.
package adsp_dag_gen_pkg;

  localparam int MAXW = 24;

  typedef logic [MAXW-1:0] word_t;
  typedef logic [MAXW:0]   wide_t;

  typedef enum logic [1:0] {
    REG_I   = 2'd0,
    REG_M   = 2'd1,
    REG_L   = 2'd2,
    REG_RSV = 2'd3
  } reg_class_t;

  // All-ones mask covering the low aw bits.
  function automatic word_t width_mask(input int aw);
    wide_t span;
    span = wide_t'(1) << aw;
    return word_t'(span - wide_t'(1));
  endfunction

  // Mask that clears the low ceil(log2(len)) bits; all ones for len 0 or 1.
  function automatic word_t len_mask(input word_t len);
    int    k;
    wide_t low;
    k = 0;
    for (int j = 0; j < MAXW; j++) begin
      if ((word_t'(1) << j) < len) k = j + 1;
    end
    low = (wide_t'(1) << k) - wide_t'(1);
    return ~word_t'(low);
  endfunction

  // Post-modify next value with circular wrap inside [b, b+l).
  function automatic word_t circ_next(input word_t i, input word_t m,
                                      input word_t l, input word_t b,
                                      input int aw);
    word_t wm;
    word_t s;
    word_t r;
    wide_t lim;
    wm  = width_mask(aw);
    s   = (i + m) & wm;
    lim = {1'b0, b} + {1'b0, l};
    r   = s;
    if (l != '0) begin
      if (!m[aw-1] && ({1'b0, s} >= lim)) r = (s - l) & wm;
      else if (m[aw-1] && (s < b))         r = (s + l) & wm;
    end
    return r;
  endfunction

  // Reverse the low aw bits of v; upper bits come back as zero.
  function automatic word_t bit_reverse(input word_t v, input int aw);
    word_t r;
    r = '0;
    for (int j = 0; j < MAXW; j++) begin
      if (j < aw) r[aw-1-j] = v[j];
    end
    return r;
  endfunction

endpackage

// File: rtl/adsp_dag_regbank.sv
// One bank of I/M/L registers plus the hidden circular base B.
// Host write port, generator I-update port, host read port, generator read port.
module adsp_dag_regbank
  import adsp_dag_gen_pkg::*;
#(
  parameter int AW   = 14,
  parameter int NREG = 4,
  parameter int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  reg_class_t    wsel,
  input  logic [IW-1:0] widx,
  input  logic [AW-1:0] wdata,
  input  logic          upd_en,
  input  logic [IW-1:0] upd_idx,
  input  logic [AW-1:0] upd_val,
  input  logic [IW-1:0] ridx,
  output logic [AW-1:0] rd_i,
  output logic [AW-1:0] rd_m,
  output logic [AW-1:0] rd_l,
  input  logic [IW-1:0] gi_idx,
  input  logic [IW-1:0] gm_idx,
  output logic [AW-1:0] g_i,
  output logic [AW-1:0] g_b,
  output logic [AW-1:0] g_l,
  output logic [AW-1:0] g_m
);

  logic [AW-1:0] i_q [NREG];
  logic [AW-1:0] m_q [NREG];
  logic [AW-1:0] l_q [NREG];
  logic [AW-1:0] b_q [NREG];

  word_t         mask_i_w;
  word_t         mask_l_w;
  logic [AW-1:0] b_from_i;
  logic [AW-1:0] b_from_l;
  logic          unused_mask_hi;

  // Base candidates: an I write masks with the stored L, an L write masks the stored I.
  always_comb begin
    mask_i_w = len_mask(word_t'(l_q[widx]));
    mask_l_w = len_mask(word_t'(wdata));
  end

  assign b_from_i       = wdata & mask_i_w[AW-1:0];
  assign b_from_l       = i_q[widx] & mask_l_w[AW-1:0];
  assign unused_mask_hi = ^{mask_i_w, mask_l_w};

  // Register storage; a host write to I lands after the generator update so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        i_q[k] <= '0;
        m_q[k] <= '0;
        l_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (upd_en && (upd_idx == IW'(k))) i_q[k] <= upd_val;
        if (we && (widx == IW'(k))) begin
          case (wsel)
            REG_I: begin
              i_q[k] <= wdata;
              b_q[k] <= b_from_i;
            end
            REG_M: m_q[k] <= wdata;
            REG_L: begin
              l_q[k] <= wdata;
              b_q[k] <= b_from_l;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign rd_i = i_q[ridx];
  assign rd_m = m_q[ridx];
  assign rd_l = l_q[ridx];
  assign g_i  = i_q[gi_idx];
  assign g_b  = b_q[gi_idx];
  assign g_l  = l_q[gi_idx];
  assign g_m  = m_q[gm_idx];

endmodule

// File: rtl/adsp_dag_gen.sv
// ADSP-style data address generator: banked I/M/L registers, pre/post
// modify with circular buffering and optional bit-reversed output.
module adsp_dag_gen
  import adsp_dag_gen_pkg::*;
#(
  parameter int AW    = 14,
  parameter int NREG  = 4,
  parameter int NBANK = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     bank,
  input  logic                     reg_we,
  input  logic [1:0]               reg_sel,
  input  logic [$clog2(NREG)-1:0]  reg_idx,
  input  logic [AW-1:0]            reg_di,
  output logic [AW-1:0]            reg_do,
  input  logic                     gen_req,
  input  logic [$clog2(NREG)-1:0]  gen_i,
  input  logic [$clog2(NREG)-1:0]  gen_m,
  input  logic                     gen_pre,
  input  logic                     bitrev,
  output logic [AW-1:0]            addr,
  output logic                     addr_vld
);

  localparam int IW = $clog2(NREG);

  logic       bank_act;
  reg_class_t reg_cls;
  logic       gen_go;
  logic       wr_go;
  logic       upd_go;

  assign bank_act = (NBANK > 1) ? bank : 1'b0;
  assign reg_cls  = reg_class_t'(reg_sel);
  assign gen_go   = ce & gen_req;
  assign wr_go    = ce & reg_we;
  assign upd_go   = gen_go & ~gen_pre;

  logic [AW-1:0] bk_rd_i [NBANK];
  logic [AW-1:0] bk_rd_m [NBANK];
  logic [AW-1:0] bk_rd_l [NBANK];
  logic [AW-1:0] bk_gi   [NBANK];
  logic [AW-1:0] bk_gb   [NBANK];
  logic [AW-1:0] bk_gl   [NBANK];
  logic [AW-1:0] bk_gm   [NBANK];

  logic [AW-1:0] nxt;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic sel_b;
    assign sel_b = (bank_act == 1'(b));

    adsp_dag_regbank #(
      .AW   (AW),
      .NREG (NREG),
      .IW   (IW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wr_go & sel_b),
      .wsel    (reg_cls),
      .widx    (reg_idx),
      .wdata   (reg_di),
      .upd_en  (upd_go & sel_b),
      .upd_idx (gen_i),
      .upd_val (nxt),
      .ridx    (reg_idx),
      .rd_i    (bk_rd_i[b]),
      .rd_m    (bk_rd_m[b]),
      .rd_l    (bk_rd_l[b]),
      .gi_idx  (gen_i),
      .gm_idx  (gen_m),
      .g_i     (bk_gi[b]),
      .g_b     (bk_gb[b]),
      .g_l     (bk_gl[b]),
      .g_m     (bk_gm[b])
    );
  end

  logic [AW-1:0] cur_rd_i, cur_rd_m, cur_rd_l;
  logic [AW-1:0] cur_gi, cur_gb, cur_gl, cur_gm;

  // Route the active bank's read ports to the datapath.
  always_comb begin
    cur_rd_i = bk_rd_i[0];
    cur_rd_m = bk_rd_m[0];
    cur_rd_l = bk_rd_l[0];
    cur_gi   = bk_gi[0];
    cur_gb   = bk_gb[0];
    cur_gl   = bk_gl[0];
    cur_gm   = bk_gm[0];
    if ((NBANK > 1) && bank_act) begin
      cur_rd_i = bk_rd_i[NBANK-1];
      cur_rd_m = bk_rd_m[NBANK-1];
      cur_rd_l = bk_rd_l[NBANK-1];
      cur_gi   = bk_gi[NBANK-1];
      cur_gb   = bk_gb[NBANK-1];
      cur_gl   = bk_gl[NBANK-1];
      cur_gm   = bk_gm[NBANK-1];
    end
  end

  word_t         nxt_w;
  word_t         rev_w;
  logic [AW-1:0] pick;
  logic [AW-1:0] addr_nxt;
  logic          unused_hi;

  // Modified address, pre/post selection and optional bit reversal of the output only.
  always_comb begin
    nxt_w    = circ_next(word_t'(cur_gi), word_t'(cur_gm), word_t'(cur_gl),
                         word_t'(cur_gb), AW);
    nxt      = nxt_w[AW-1:0];
    pick     = gen_pre ? nxt : cur_gi;
    rev_w    = bit_reverse(word_t'(pick), AW);
    addr_nxt = bitrev ? rev_w[AW-1:0] : pick;
  end

  assign unused_hi = ^{nxt_w, rev_w};

  logic [AW-1:0] do_nxt;

  // Read-back value as it will stand after this cycle's write and I update.
  always_comb begin
    do_nxt = '0;
    if (wr_go && (reg_cls != REG_RSV)) begin
      do_nxt = reg_di;
    end else begin
      case (reg_cls)
        REG_I:   do_nxt = (upd_go && (gen_i == reg_idx)) ? nxt : cur_rd_i;
        REG_M:   do_nxt = cur_rd_m;
        REG_L:   do_nxt = cur_rd_l;
        default: do_nxt = '0;
      endcase
    end
  end

  // Registered outputs; the valid pulse drops whenever no request was taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      addr_vld <= 1'b0;
      reg_do   <= '0;
    end else if (ce) begin
      addr_vld <= gen_req;
      if (gen_req) addr <= addr_nxt;
      reg_do   <= do_nxt;
    end else begin
      addr_vld <= 1'b0;
    end
  end

endmodule

// File: doc/adsp_dag_gen.md
ADSP_DAG_GEN -- requirements
Module: adsp_dag_gen

Interface
REQ-001 Parameter AW, default 14: address/register width in bits (legal range 8..24).
REQ-002 Parameter NREG, default 4: I/M/L register sets per bank (power of 2, 2..16); IW = log2(NREG).
REQ-003 Parameter NBANK, default 2: register banks (1 or 2); bank 1 is the secondary set.
REQ-004 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 CE  in  1  clock enable; when 0 all state holds and outputs are unchanged.
REQ-007 BANK  in  1  active bank select; ignored when NBANK=1.
REQ-008 REG_WE  in  1  register write strobe.
REQ-009 REG_SEL  in  2  register class: 0=I, 1=M, 2=L, 3=reserved (write ignored, read returns 0).
REQ-010 REG_IDX  in  IW  register index for the read and write ports.
REQ-011 REG_DI  in  AW  register write data.
REQ-012 REG_DO  out  AW  registered read data for REG_SEL/REG_IDX in the active bank.
REQ-013 GEN_REQ  in  1  address generation request.
REQ-014 GEN_I, GEN_M  in  IW each  I and M register indices for the request.
REQ-015 GEN_PRE  in  1  1 = pre-modify: output I+M, I unchanged; 0 = post-modify: output I, I := next.
REQ-016 BITREV  in  1  1 = output address bit-reversed over all AW bits.
REQ-017 ADDR  out  AW  generated address.
REQ-018 ADDR_VLD  out  1  one-cycle pulse qualifying ADDR.

Function
REQ-019 M SHALL be treated as two's-complement signed AW-bit; I, L and base B as unsigned.
REQ-020 Each I register SHALL have a hidden base B, latched on any write to I or to the L of the same index: B = I & mask, where mask clears the low ceil(log2(L)) bits (B = I when L=0).
REQ-021 Next value: S = I+M (mod 2^AW); L=0 -> next = S; L!=0 and M>=0 and S >= B+L -> next = S-L; L!=0 and M<0 and S < B -> next = S+L; otherwise next = S.
REQ-022 Circular correctness is guaranteed only for |M| <= L; other values SHALL still produce the deterministic formula result, never X.
REQ-023 Latency: ADDR and ADDR_VLD SHALL be registered, valid the cycle after GEN_REQ sampled with CE=1; I update visible to a request in the immediately following cycle (back-to-back requests on one I stream correctly).
REQ-024 ADDR SHALL be I (post) or next (pre), passed through bit reversal when BITREV=1; bit reversal never affects the stored I.
REQ-025 Simultaneous REG_WE to I[k] and post-modify update of I[k]: the register write SHALL win and B re-latches from REG_DI; ADDR still reflects the pre-write I.
REQ-026 Simultaneous REG_WE to M[k] or L[k] used by the same request: the request SHALL use old values.
REQ-027 REG_DO SHALL reflect the value after all same-cycle updates, one cycle after address presentation.
REQ-028 BANK change SHALL take effect for requests and register access sampled in the same cycle; the inactive bank holds its contents unaltered.
REQ-029 ADDR_VLD SHALL be 0 whenever GEN_REQ=0 or CE=0 in the preceding sampled cycle; ADDR holds its last value.

Reset
REQ-030 RST_N low SHALL asynchronously clear all I, M, L, B in every bank, REG_DO, ADDR and ADDR_VLD to 0.
REQ-031 Reset mid-request SHALL discard the request; first valid request is the first GEN_REQ sampled with RST_N high and CE=1.

Structure
REQ-032 Register-class enum (I/M/L), the circular-wrap function, mask-from-length function and parametrised bit-reverse function SHALL live in the shared ADSP package.
REQ-033 One sub-module adsp_dag_regbank (one bank of I/M/L/B storage, one write port, two read ports) SHALL be instantiated NBANK times.

Verification
REQ-034 Linear: L0=0, I0=0x100, M0=3, three post-modify requests -> ADDR 0x100,0x103,0x106 on consecutive cycles; I0 ends 0x109.
REQ-035 Circular wrap: L0=10, I0=0x208 (B=0x200), M0=4 -> ADDR 0x208, 0x202, 0x206; negative M0=-4 from I0=0x201 -> ADDR 0x201 then I0=0x207.
REQ-036 Pre-modify and bit-reverse: AW=14, I1=0x0001, M1=1, GEN_PRE=1, BITREV=1 -> ADDR 0x1000, I1 stays 0x0001.
REQ-037 Collision: post-modify on I2=0x40,M2=1 while REG_WE writes I2=0x80 -> ADDR 0x40, I2 reads 0x80.
REQ-038 Banks: write I0=0x11 in bank 0, I0=0x22 in bank 1; request with BANK=1 -> ADDR 0x22; bank 0 I0 still 0x11.
REQ-039 Reset: assert RST_N low asynchronously between clock edges during a request stream -> ADDR_VLD and ADDR 0 immediately; all registers read 0 after release.
